// File: rtl/traffic_light_pkg.sv
// Shared types and constants for the traffic light controller:
// phase state enum, one-hot lamp encodings and phase counter width.
package traffic_light_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    RED    = 2'b00,
    GREEN  = 2'b01,
    YELLOW = 2'b10
  } state_t;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

endpackage

// File: rtl/tl_phase_timer.sv
// Loadable phase down-counter; saturates at zero.
// Ports: clk, rst_n (async low), load, load_value[7:0], done (count==0).
module tl_phase_timer
  import traffic_light_pkg::*;
#(
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             done
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= RST_VAL;
    end else if (load) begin
      r_cnt <= load_value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign done = (r_cnt == '0);

endmodule

// File: rtl/traffic_light.sv
// Fixed-cycle traffic light: RED -> GREEN -> YELLOW -> RED.
// Ports: clk, reset (async low), light[2:0] (red,yellow,green; registered).
module traffic_light
  import traffic_light_pkg::*;
#(
  parameter int unsigned RED_TIME    = 10,
  parameter int unsigned GREEN_TIME  = 8,
  parameter int unsigned YELLOW_TIME = 3
) (
  input  logic       clk,
  input  logic       reset,
  output logic [2:0] light
);

  if ((RED_TIME < 1) || (RED_TIME > 255) ||
      (GREEN_TIME < 1) || (GREEN_TIME > 255) ||
      (YELLOW_TIME < 1) || (YELLOW_TIME > 255)) begin : g_bad_time
    $error("traffic_light: phase durations must be 1..255");
  end

  localparam logic [CNT_W-1:0] RED_LD = CNT_W'(RED_TIME - 1);
  localparam logic [CNT_W-1:0] GRN_LD = CNT_W'(GREEN_TIME - 1);
  localparam logic [CNT_W-1:0] YEL_LD = CNT_W'(YELLOW_TIME - 1);

  state_t           r_state;
  logic [2:0]       r_light;
  state_t           w_next;
  logic             w_load;
  logic [CNT_W-1:0] w_ld_val;
  logic [2:0]       w_light;
  logic             w_done;

  tl_phase_timer #(
    .RST_VAL (RED_LD)
  ) u_timer (
    .clk        (clk),
    .rst_n      (reset),
    .load       (w_load),
    .load_value (w_ld_val),
    .done       (w_done)
  );

  always_comb begin
    w_next   = r_state;
    w_load   = 1'b0;
    w_ld_val = RED_LD;
    unique case (r_state)
      RED: begin
        if (w_done) begin
          w_next   = GREEN;
          w_load   = 1'b1;
          w_ld_val = GRN_LD;
        end
      end
      GREEN: begin
        if (w_done) begin
          w_next   = YELLOW;
          w_load   = 1'b1;
          w_ld_val = YEL_LD;
        end
      end
      YELLOW: begin
        if (w_done) begin
          w_next   = RED;
          w_load   = 1'b1;
          w_ld_val = RED_LD;
        end
      end
      default: begin
        // Corrupted state: restart a full red phase
        w_next   = RED;
        w_load   = 1'b1;
        w_ld_val = RED_LD;
      end
    endcase
  end

  always_comb begin
    w_light = LIGHT_RED;
    unique case (w_next)
      RED:     w_light = LIGHT_RED;
      GREEN:   w_light = LIGHT_GREEN;
      YELLOW:  w_light = LIGHT_YELLOW;
      default: w_light = LIGHT_RED;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RED;
      r_light <= LIGHT_RED;
    end else begin
      r_state <= w_next;
      r_light <= w_light;
    end
  end

  assign light = r_light;

endmodule

// File: tb/tb_traffic_light.sv
// Bench for traffic_light: cycle-count model plus directed checks,
// default timing instance and a 1/1/1 instance on a shared clock/reset.
module tb_traffic_light;
  import traffic_light_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] light_a;
  logic [2:0] light_b;

  int n_chk = 0;
  int n_fail = 0;
  int t_a = 0;
  int t_b = 0;
  bit force_a = 1'b0;

  always #5 clk = ~clk;

  traffic_light dut_a (
    .clk   (clk),
    .reset (rst_n),
    .light (light_a)
  );

  traffic_light #(
    .RED_TIME    (1),
    .GREEN_TIME  (1),
    .YELLOW_TIME (1)
  ) dut_b (
    .clk   (clk),
    .reset (rst_n),
    .light (light_b)
  );

  // Lamp expected t edges into a cycle that started in red
  function automatic logic [2:0] exp_light(
    input int t, input int r, input int g, input int y
  );
    int m;
    m = t % (r + g + y);
    if (m < r) return 3'b100;
    if (m < r + g) return 3'b001;
    return 3'b010;
  endfunction

  task automatic chk(
    input string name, input logic [2:0] got, input logic [2:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic wait_green(output bit found);
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (light_a == 3'b001) found = 1'b1;
    end
    n_chk++;
    if (!found) begin
      n_fail++;
      $display("FAIL wait_green: got timeout expected green within 40");
    end
  endtask

  // Model: edges elapsed since red was (re)entered
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_a = 0;
      t_b = 0;
    end else begin
      if (force_a) begin
        t_a = 0;
        force_a = 1'b0;
      end else begin
        t_a++;
      end
      t_b++;
    end
  end

  always @(negedge clk) begin
    chk("model_a", light_a, exp_light(t_a, 10, 8, 3));
    chk("model_b", light_b, exp_light(t_b, 1, 1, 1));
  end

  initial begin
    bit found;
    int g_prev;
    logic [2:0] prev;

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_a", light_a, 3'b100);
    chk("reset_b", light_b, 3'b100);
    rst_n = 1'b1;

    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      if (k == 1) chk("b_green", light_b, 3'b001);
      if (k == 2) chk("b_yellow", light_b, 3'b010);
      if (k == 3) chk("b_red", light_b, 3'b100);
      if (k == 9) chk("red_last", light_a, 3'b100);
      if (k == 10) chk("green_first", light_a, 3'b001);
      if (k == 17) chk("green_last", light_a, 3'b001);
      if (k == 18) chk("yellow_first", light_a, 3'b010);
      if (k == 20) chk("yellow_last", light_a, 3'b010);
      if (k == 21) chk("red_again", light_a, 3'b100);
    end

    g_prev = -1;
    prev = light_a;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (light_a == 3'b001 && prev != 3'b001) begin
        if (g_prev >= 0) begin
          n_chk++;
          if (c - g_prev != 21) begin
            n_fail++;
            $display("FAIL period: got %0d expected 21", c - g_prev);
          end
        end
        g_prev = c;
      end
      prev = light_a;
    end

    wait_green(found);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_a", light_a, 3'b100);
    chk("async_rst_b", light_b, 3'b100);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 9) chk("post_rst_red", light_a, 3'b100);
      if (k == 10) chk("post_rst_green", light_a, 3'b001);
    end

    wait_green(found);
    @(negedge clk);
    force dut_a.r_state = state_t'(2'b11);
    force_a = 1'b1;
    #1 release dut_a.r_state;
    @(negedge clk);
    chk("illegal_recover", light_a, 3'b100);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 9) chk("illegal_red_last", light_a, 3'b100);
      if (k == 10) chk("illegal_green", light_a, 3'b001);
    end

    repeat (25) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
